// File: rtl/alu_writeback.sv
// ALU writeback stage: a 2-entry FIFO buffers ALU results and retires them in order.
// The head entry updates the A/D registers, the program counter and optionally memory.
// Define WB_PERF_EN to add the retire_cnt / stall_cnt performance counters.
module alu_writeback (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] alu_out,
    input  logic        zr,
    input  logic        ng,
    input  logic [2:0]  dest,
    input  logic [2:0]  jmp,
    input  logic        m_ready,
    output logic        m_we,
    output logic [15:0] m_out,
    output logic [15:0] m_addr,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic [15:0] pc,
    output logic        retired
`ifdef WB_PERF_EN
    ,
    output logic [15:0] retire_cnt,
    output logic [15:0] stall_cnt
`endif
);

    typedef struct packed {
        logic [15:0] alu;
        logic        zr;
        logic        ng;
        logic [2:0]  dest;
        logic [2:0]  jmp;
    } entry_t;

    entry_t      fifo_q [2];
    logic        rdPtr_q;
    logic        wrPtr_q;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic [15:0] aReg_q;
    logic [15:0] aReg_d;
    logic [15:0] dReg_q;
    logic [15:0] dReg_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;

    logic        push;
    logic        pop;
    logic        headValid;
    logic        taken;
    entry_t      head;
    entry_t      incoming;

    // in_ready depends only on registered occupancy, never on m_ready.
    assign in_ready  = (count_q != 2'd2);
    assign push      = in_valid & in_ready;
    assign headValid = (count_q != 2'd0);
    assign head      = fifo_q[rdPtr_q];
    assign pop       = headValid & (~head.dest[0] | m_ready);
    assign taken     = (head.jmp[2] & head.ng) | (head.jmp[1] & head.zr) |
                       (head.jmp[0] & ~head.ng & ~head.zr);
    assign incoming  = '{alu: alu_out, zr: zr, ng: ng, dest: dest, jmp: jmp};

    assign m_we    = headValid & head.dest[0];
    assign m_out   = head.alu;
    assign m_addr  = aReg_q;
    assign retired = pop;
    assign a_reg   = aReg_q;
    assign d_reg   = dReg_q;
    assign pc      = pc_q;

    // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Architectural register update from the retiring head; hold otherwise.
    always_comb begin
        aReg_d = aReg_q;
        dReg_d = dReg_q;
        pc_d   = pc_q;
        if (pop) begin
            if (head.dest[2]) aReg_d = head.alu;
            if (head.dest[1]) dReg_d = head.alu;
            pc_d = taken ? aReg_q : (pc_q + 16'd1);
        end
    end

    // FIFO storage, pointers and occupancy; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wrPtr_q] <= incoming;
                wrPtr_q         <= ~wrPtr_q;
            end
            if (pop) rdPtr_q <= ~rdPtr_q;
            count_q <= count_d;
        end
    end

    // A, D and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aReg_q <= 16'h0000;
            dReg_q <= 16'h0000;
            pc_q   <= 16'h0000;
        end else begin
            aReg_q <= aReg_d;
            dReg_q <= dReg_d;
            pc_q   <= pc_d;
        end
    end

`ifdef WB_PERF_EN
    logic [15:0] retireCnt_q;
    logic [15:0] stallCnt_q;

    assign retire_cnt = retireCnt_q;
    assign stall_cnt  = stallCnt_q;

    // Saturating counters of retirements and of cycles a memory write is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retireCnt_q <= 16'h0000;
            stallCnt_q  <= 16'h0000;
        end else begin
            if (pop && (retireCnt_q != 16'hFFFF)) retireCnt_q <= retireCnt_q + 16'd1;
            if (m_we && !m_ready && (stallCnt_q != 16'hFFFF)) stallCnt_q <= stallCnt_q + 16'd1;
        end
    end
`endif

endmodule
